// File: rtl/spi_ip_sck_engine.sv
// spi_ip_sck_engine
//   SPI serial-clock engine. A start frames one transfer of N SCK cycles:
//   a lead guard half-period, 2N SCK edges, and a trail guard half-period.
//   It emits launch/capture strobes for the shift register, and busy/done
//   status for the control FSM. An abort ends the transfer at once.
//
// Ports
//   se_clk_i, se_rst_i     clock, asynchronous active-high reset
//   se_start_i             start request; accepted only in IDLE
//   se_abort_i             abort the running transfer
//   se_nbits_i             bits per transfer N (latched at start)
//   se_half_period_i       SCK half-period minus one (latched at start)
//   se_cpol_i, se_cpha_i   SPI mode (latched at start; cpol tracked in IDLE)
//   se_sck_o               registered serial clock
//   se_launch_o            1-cycle pulse: drive next bit
//   se_capture_o           1-cycle pulse: sample bit
//   se_busy_o, se_done_o   transfer status / completion pulse
//   se_bit_idx_o           number of bits captured in the current/last transfer
//   se_dbg_state_o         current FSM state, for debug visibility
//
// Handshake: se_start_i is a level request with no ready. It is accepted
// on a clock edge where the engine is IDLE and se_abort_i is low.
// Requests that arrive while a transfer runs are dropped, not queued.
module spi_ip_sck_engine #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             se_clk_i,
  input  logic             se_rst_i,
  input  logic             se_start_i,
  input  logic             se_abort_i,
  input  logic [CNT_W-1:0] se_nbits_i,
  input  logic [DIV_W-1:0] se_half_period_i,
  input  logic             se_cpol_i,
  input  logic             se_cpha_i,
  output logic             se_sck_o,
  output logic             se_launch_o,
  output logic             se_capture_o,
  output logic             se_busy_o,
  output logic             se_done_o,
  output logic [CNT_W-1:0] se_bit_idx_o,
  output logic [1:0]       se_dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_RUN, S_TRAIL} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W:0]   r_edge, w_edge_nxt;
  logic             r_first, w_first_nxt;
  logic             r_zero_pend, w_zero_pend_nxt;
  logic [CNT_W-1:0] r_nbits, w_nbits_nxt;
  logic [DIV_W-1:0] r_hp, w_hp_nxt;
  logic             r_cpol, w_cpol_nxt;
  logic             r_cpha, w_cpha_nxt;
  logic             r_sck, w_sck_nxt;
  logic             r_launch, w_launch_nxt;
  logic             r_capture, w_capture_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] r_bit_idx, w_bit_idx_nxt;

  logic             w_tick;
  logic [CNT_W:0]   w_edge_k;
  logic             w_last_edge;
  logic             w_edge_capture;
  logic             w_edge_launch;

  assign w_tick      = (r_cnt == '0);
  assign w_edge_k    = r_edge + 1'b1;
  assign w_last_edge = (w_edge_k == {r_nbits, 1'b0});
  // Odd edges capture in mode CPHA=0, even edges in CPHA=1.
  // The final edge of a CPHA=0 transfer has no bit left to launch.
  assign w_edge_capture = (w_edge_k[0] != r_cpha);
  assign w_edge_launch  = !w_edge_capture && !(w_last_edge && !r_cpha);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_edge_nxt      = r_edge;
    w_first_nxt     = r_first;
    w_zero_pend_nxt = r_zero_pend;
    w_nbits_nxt     = r_nbits;
    w_hp_nxt        = r_hp;
    w_cpol_nxt      = r_cpol;
    w_cpha_nxt      = r_cpha;
    w_sck_nxt       = r_sck;
    w_launch_nxt    = 1'b0;
    w_capture_nxt   = 1'b0;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    // bit_idx trails each visible capture pulse by one cycle.
    w_bit_idx_nxt   = r_capture ? r_bit_idx + 1'b1 : r_bit_idx;

    case (r_state)
      S_IDLE: begin
        w_sck_nxt  = se_cpol_i;
        w_busy_nxt = 1'b0;
        if (r_zero_pend) begin
          // Zero-length transfer: completion reported one cycle after start.
          w_done_nxt      = 1'b1;
          w_zero_pend_nxt = 1'b0;
        end else if (se_start_i && !se_abort_i) begin
          w_nbits_nxt   = se_nbits_i;
          w_hp_nxt      = se_half_period_i;
          w_cpol_nxt    = se_cpol_i;
          w_cpha_nxt    = se_cpha_i;
          w_bit_idx_nxt = '0;
          if (se_nbits_i == '0) begin
            w_zero_pend_nxt = 1'b1;
          end else begin
            w_state_nxt = S_LEAD;
            w_cnt_nxt   = se_half_period_i;
            w_edge_nxt  = '0;
            w_first_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (se_abort_i) begin
          w_state_nxt = S_IDLE;
          w_sck_nxt   = r_cpol;
          w_busy_nxt  = 1'b0;
          w_first_nxt = 1'b0;
        end else begin
          case (r_state)
            S_LEAD: begin
              if (r_first) begin
                // The first LEAD cycle raises busy and sets up bit 0 for CPHA=0.
                // The counter is held in this cycle, so the lead lasts H full cycles.
                w_first_nxt  = 1'b0;
                w_busy_nxt   = 1'b1;
                w_launch_nxt = !r_cpha;
              end else if (w_tick) begin
                w_cnt_nxt     = r_hp;
                w_sck_nxt     = !r_sck;
                w_edge_nxt    = w_edge_k;
                w_capture_nxt = w_edge_capture;
                w_launch_nxt  = w_edge_launch;
                w_state_nxt   = S_RUN;
              end else begin
                w_cnt_nxt = r_cnt - 1'b1;
              end
            end
            S_RUN: begin
              if (w_tick) begin
                w_cnt_nxt     = r_hp;
                w_sck_nxt     = !r_sck;
                w_edge_nxt    = w_edge_k;
                w_capture_nxt = w_edge_capture;
                w_launch_nxt  = w_edge_launch;
                if (w_last_edge) w_state_nxt = S_TRAIL;
              end else begin
                w_cnt_nxt = r_cnt - 1'b1;
              end
            end
            S_TRAIL: begin
              if (w_tick) begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_sck_nxt   = r_cpol;
                w_state_nxt = S_IDLE;
              end else begin
                w_cnt_nxt = r_cnt - 1'b1;
              end
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge se_clk_i or posedge se_rst_i) begin
    if (se_rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_edge      <= '0;
      r_first     <= 1'b0;
      r_zero_pend <= 1'b0;
      r_nbits     <= '0;
      r_hp        <= '0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_sck       <= 1'b0;
      r_launch    <= 1'b0;
      r_capture   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bit_idx   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_edge      <= w_edge_nxt;
      r_first     <= w_first_nxt;
      r_zero_pend <= w_zero_pend_nxt;
      r_nbits     <= w_nbits_nxt;
      r_hp        <= w_hp_nxt;
      r_cpol      <= w_cpol_nxt;
      r_cpha      <= w_cpha_nxt;
      r_sck       <= w_sck_nxt;
      r_launch    <= w_launch_nxt;
      r_capture   <= w_capture_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
    end
  end

  assign se_sck_o       = r_sck;
  assign se_launch_o    = r_launch;
  assign se_capture_o   = r_capture;
  assign se_busy_o      = r_busy;
  assign se_done_o      = r_done;
  assign se_bit_idx_o   = r_bit_idx;
  assign se_dbg_state_o = r_state;

endmodule

// File: tb/tb_spi_ip_sck_engine.sv
// Directed bench for spi_ip_sck_engine. Cycle numbers are counted from the
// start edge t0. Outputs are sampled 1 time unit after each rising edge.
module tb_spi_ip_sck_engine;

  localparam int DIV_W = 8;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] nbits = '0;
  logic [DIV_W-1:0] hp = '0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic             sck, launch, capture, busy, done;
  logic [CNT_W-1:0] bit_idx;
  logic [1:0]       dbg_state;

  int vectors = 0;
  int miscompares = 0;

  spi_ip_sck_engine #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .se_clk_i         (clk),
    .se_rst_i         (rst),
    .se_start_i       (start),
    .se_abort_i       (abort),
    .se_nbits_i       (nbits),
    .se_half_period_i (hp),
    .se_cpol_i        (cpol),
    .se_cpha_i        (cpha),
    .se_sck_o         (sck),
    .se_launch_o      (launch),
    .se_capture_o     (capture),
    .se_busy_o        (busy),
    .se_done_o        (done),
    .se_bit_idx_o     (bit_idx),
    .se_dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues a start and runs until done, with a bound on the number of cycles.
  // With meddle set, the inputs are changed and start is re-pulsed mid-transfer.
  task automatic run_xfer(input int n, input int h_m1, input bit pol, input bit pha,
                          input bit meddle,
                          output int done_at, output int first_l, output int first_c,
                          output int n_l, output int n_c, output int n_tog, output int n_both);
    logic prev;
    done_at = -1; first_l = -1; first_c = -1;
    n_l = 0; n_c = 0; n_tog = 0; n_both = 0;
    nbits = n[CNT_W-1:0]; hp = h_m1[DIV_W-1:0]; cpol = pol; cpha = pha;
    start = 1'b1;
    step();                      // t0
    start = 1'b0;
    prev = sck;
    for (int c = 1; c <= 3000; c++) begin
      if (meddle && c == 3) begin
        nbits = 7; hp = 5; cpol = ~pol; cpha = ~pha; start = 1'b1;
      end
      if (meddle && c == 4) start = 1'b0;
      step();
      if (launch) begin n_l++; if (first_l < 0) first_l = c; end
      if (capture) begin n_c++; if (first_c < 0) first_c = c; end
      if (launch && capture) n_both++;
      if (sck !== prev) n_tog++;
      prev = sck;
      if (done) begin done_at = c; break; end
    end
  endtask

  int d, fl, fc, nl, nc, nt, nb, caps, c_at, extra;

  initial begin
    // Reset
    step(); step();
    check("rst_sck", sck, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {launch, capture, done}, 0);
    check("rst_bit_idx", bit_idx, 0);
    rst = 1'b0;
    step();

    // 1: H=1, N=1, mode 0
    nbits = 1; hp = 0; cpol = 0; cpha = 0; start = 1'b1;
    step();                                   // t0
    start = 1'b0;
    check("t1_t0_busy", busy, 0);
    step();                                   // t1
    check("t1_t1_busy", busy, 1);
    check("t1_t1_launch", launch, 1);
    check("t1_t1_sck", sck, 0);
    step();                                   // t2
    check("t1_t2_sck", sck, 1);
    check("t1_t2_capture", capture, 1);
    check("t1_t2_launch", launch, 0);
    step();                                   // t3
    check("t1_t3_sck", sck, 0);
    check("t1_t3_bit_idx", bit_idx, 1);
    check("t1_t3_done", done, 0);
    step();                                   // t4
    check("t1_t4_done", done, 1);
    check("t1_t4_busy", busy, 0);
    step();
    check("t1_t5_done", done, 0);

    // 2: H=4, N=8, all modes
    for (int m = 0; m < 4; m++) begin
      cpol = m[1]; cpha = m[0];
      step(); step();
      check("t2_idle_sck", sck, m[1]);
      run_xfer(8, 3, m[1], m[0], 1'b0, d, fl, fc, nl, nc, nt, nb);
      check("t2_done_at", d, 69);
      check("t2_launches", nl, 8);
      check("t2_captures", nc, 8);
      check("t2_toggles", nt, 16);
      check("t2_both", nb, 0);
      check("t2_first_launch", fl, m[0] ? 5 : 1);
      check("t2_first_capture", fc, m[0] ? 9 : 5);
      check("t2_sck_end", sck, m[1]);
      check("t2_bit_idx", bit_idx, 8);
      check("t2_busy_end", busy, 0);
    end

    // 3: maximum half-period, no counter wrap
    run_xfer(2, 255, 1'b0, 1'b0, 1'b0, d, fl, fc, nl, nc, nt, nb);
    check("t3_done_at", d, 1 + 5 * 256);
    check("t3_toggles", nt, 4);
    check("t3_first_capture", fc, 1 + 256);
    check("t3_launches", nl, 2);
    check("t3_captures", nc, 2);

    // 4: abort after the 3rd capture (N=8, H=2, CPOL=1)
    nbits = 8; hp = 1; cpol = 1; cpha = 0; start = 1'b1;
    step();                                   // t0
    start = 1'b0;
    caps = 0; c_at = -1;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (capture) caps++;
      if (caps == 3) begin c_at = c; break; end
    end
    check("t4_third_capture_at", c_at, 11);
    check("t4_sck_before_abort", sck, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_sck", sck, 1);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_bit_idx", bit_idx, 3);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (launch || capture || done || sck !== 1'b1) extra++;
    end
    check("t4_quiet_after_abort", extra, 0);
    check("t4_bit_idx_hold", bit_idx, 3);

    // 5: start and config changes mid-transfer are ignored
    run_xfer(3, 1, 1'b0, 1'b0, 1'b1, d, fl, fc, nl, nc, nt, nb);
    check("t5_done_at", d, 1 + 7 * 2);
    check("t5_launches", nl, 3);
    check("t5_captures", nc, 3);
    check("t5_toggles", nt, 6);
    check("t5_first_capture", fc, 3);
    check("t5_bit_idx", bit_idx, 3);

    // 6a: N=0 gives a single done pulse
    cpol = 0; cpha = 0; step(); step();
    nbits = 0; hp = 2; start = 1'b1;
    step();                                   // t0
    start = 1'b0;
    check("t6_t0_done", done, 0);
    step();
    check("t6_t1_done", done, 1);
    check("t6_t1_busy", busy, 0);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done || busy || sck || launch || capture) extra++;
    end
    check("t6_zero_quiet", extra, 0);

    // 6b: reset asserted mid-RUN
    nbits = 8; hp = 1; cpol = 0; cpha = 0; start = 1'b1;
    step();                                   // t0
    start = 1'b0;
    for (int c = 0; c < 7; c++) step();       // t7
    check("t6_pre_rst_sck", sck, 1);
    check("t6_pre_rst_busy", busy, 1);
    step();                                   // t8
    check("t6_pre_rst_bit_idx", bit_idx, 2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_sck", sck, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pulses", {launch, capture, done}, 0);
    check("t6_rst_bit_idx", bit_idx, 0);
    check("t6_rst_state", dbg_state, 0);
    step();
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
